// File: rtl/wbs_uart_tx_pkg.sv
// wbs_uart_tx_pkg: register map, STATUS layout and serialiser states for wbs_uart_tx.
// WBS_UART_TX_PARITY_EN adds the PARITY state between DATA and STOP.
package wbs_uart_tx_pkg;
  localparam logic [15:0] ADDR_TXDATA  = 16'h0000;
  localparam logic [15:0] ADDR_STATUS  = 16'h0001;
  localparam logic [15:0] ADDR_BAUDDIV = 16'h0002;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_LEVEL = 8;
  localparam logic [15:0] BAUDDIV_MIN = 16'd2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef WBS_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
endpackage

// File: rtl/wbs_uart_tx_fifo.sv
// wbs_uart_tx_fifo: byte FIFO with level count; full/empty derive from the registered level.
module wbs_uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) level <= do_push ? level + (AW+1)'(1) : level - (AW+1)'(1);
    end
  always_ff @(posedge wb_clk_i)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/wbs_uart_tx.sv
// wbs_uart_tx: Wishbone B4 pipelined slave feeding a FIFO-buffered 8N1 UART transmitter.
// Define WBS_UART_TX_PARITY_EN to append an even-parity bit (11-bit frame).
module wbs_uart_tx
  import wbs_uart_tx_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter logic [15:0] BAUD_RESET = 16'd104
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        uart_tx_o
);
  state_t state, state_nx;
  logic [15:0] baud, cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] sh, sh_nx, dout;
  logic [$clog2(DEPTH):0] level;
  logic [31:0] status, rd_data;
  logic empty, full, busy, accept, push, pop, tx_nx, unused;
  assign unused     = ^{wb_sel_i[3:2], wb_dat_i[31:16]};
  assign busy       = state != S_IDLE;
  assign wb_stall_o = wb_cyc_i && wb_stb_i && wb_we_i && wb_adr_i == ADDR_TXDATA && wb_sel_i[0] && full;
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;
  assign push       = accept && wb_we_i && wb_adr_i == ADDR_TXDATA && wb_sel_i[0];
  always_comb begin
    status = '0;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL] = full;
    status[STAT_BUSY] = busy;
    status[STAT_LEVEL +: 8] = 8'(level);
  end
  assign rd_data = wb_we_i ? '0 :
                   wb_adr_i == ADDR_STATUS ? status :
                   wb_adr_i == ADDR_BAUDDIV ? {16'h0, baud} : '0;
  wbs_uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .push(push), .pop(pop), .din(wb_dat_i[7:0]),
    .dout(dout), .empty(empty), .full(full), .level(level)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      baud     <= BAUD_RESET;
    end else begin
      wb_ack_o <= accept;
      if (accept) wb_dat_o <= rd_data;
      if (accept && wb_we_i && wb_adr_i == ADDR_BAUDDIV && wb_sel_i[1:0] == 2'b11)
        baud <= wb_dat_i[15:0] < BAUDDIV_MIN ? BAUDDIV_MIN : wb_dat_i[15:0];
    end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      sh        <= sh_nx;
      uart_tx_o <= tx_nx;
    end
  // cnt counts down the current bit; the divider is reloaded at every bit boundary
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sh_nx    = sh;
    tx_nx    = uart_tx_o;
    pop      = 1'b0;
    if (state == S_IDLE) begin
      tx_nx = 1'b1;
      if (!empty) begin
        pop      = 1'b1;
        sh_nx    = dout;
        state_nx = S_START;
        tx_nx    = 1'b0;
        cnt_nx   = baud - 16'd1;
      end
    end else if (cnt != '0) begin
      cnt_nx = cnt - 16'd1;
    end else begin
      cnt_nx = baud - 16'd1;
      case (state)
        S_START: begin
          state_nx = S_DATA;
          idx_nx   = '0;
          tx_nx    = sh[0];
        end
        S_DATA: begin
          if (idx == 3'd7) begin
`ifdef WBS_UART_TX_PARITY_EN
            state_nx = S_PARITY;
            tx_nx    = ^sh;
`else
            state_nx = S_STOP;
            tx_nx    = 1'b1;
`endif
          end else begin
            idx_nx = idx + 3'd1;
            tx_nx  = sh[idx + 3'd1];
          end
        end
`ifdef WBS_UART_TX_PARITY_EN
        S_PARITY: begin
          state_nx = S_STOP;
          tx_nx    = 1'b1;
        end
`endif
        S_STOP: begin
          state_nx = S_IDLE;
          tx_nx    = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end
endmodule
